// File: rtl/sudoku_wb_pkg.sv
// Shared types and address map for the sudoku accelerator Wishbone front end.
// Holds the arbiter state encoding and the slave window constants.
package sudoku_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS0,
        ST_BUS1,
        ST_ABORT0,
        ST_ABORT1
    } state_t;

    localparam logic [31:0] SUDOKU_BASE = 32'h3000_0000;
    localparam logic [31:0] UART_BASE   = 32'h3080_0000;
    localparam logic [31:0] WIN_MASK    = 32'hFFF0_0000;

    function automatic logic in_window(
        input logic [31:0] adr,
        input logic [31:0] base
    );
        return (adr & WIN_MASK) == base;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-strobe wait counter for the Wishbone arbiter.
// Flags expiry on the last allowed wait cycle; TIMEOUT=0 disables it.
module wb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [TW-1:0] cnt;

    // Count stalled strobe cycles, restart whenever the stall ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = en & (cnt == TW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/sudoku_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter for the accelerator slave.
// Grants whole bus cycles and aborts hung transfers with an error.
module sudoku_wb_arbiter
    import sudoku_wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    state_t state;
    state_t next;
    logic   last;
    logic   wd_en;
    logic   expire;

    wire req0 = m0_cyc_i & m0_stb_i;
    wire req1 = m1_cyc_i & m1_stb_i;

    assign wd_en = ((state == ST_BUS0) || (state == ST_BUS1))
                 & s_stb_o & ~s_ack_i;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .en     (wd_en),
        .clr    (~wd_en),
        .expire (expire)
    );

    // State and round-robin history; last owner is recorded on release
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= next;
            if ((state == ST_BUS0 && next == ST_IDLE) || state == ST_ABORT0)
                last <= 1'b0;
            else if ((state == ST_BUS1 && next == ST_IDLE) || state == ST_ABORT1)
                last <= 1'b1;
        end
    end

    // Next-state selection and owner-to-slave routing
    always_comb begin
        next      = state;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_dat_o  = '0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req0 && req1)
                    next = last ? ST_BUS0 : ST_BUS1;
                else if (req0)
                    next = ST_BUS0;
                else if (req1)
                    next = ST_BUS1;
            end
            ST_BUS0: begin
                grant_o  = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                if (!m0_cyc_i)
                    next = ST_IDLE;
                else if (expire)
                    next = ST_ABORT0;
            end
            ST_BUS1: begin
                grant_o  = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                if (!m1_cyc_i)
                    next = ST_IDLE;
                else if (expire)
                    next = ST_ABORT1;
            end
            ST_ABORT0: begin
                grant_o   = 2'b01;
                m0_err_o  = 1'b1;
                timeout_o = 1'b1;
                next      = ST_IDLE;
            end
            ST_ABORT1: begin
                grant_o   = 2'b10;
                m1_err_o  = 1'b1;
                timeout_o = 1'b1;
                next      = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/sudoku_wb_arbiter.md
Name: sudoku_wb_arbiter

Overview:
Two-master Wishbone (classic, non-pipelined) arbiter in front of the accelerator's single slave port, which carries both the sudoku and UART windows.
- Master 0 is the management SoC bus.
- Master 1 is the host debug bridge.
- Grants whole bus cycles (cyc-to-cyc) round-robin.
- Runs a per-transfer watchdog that aborts a hung slave with an error to the requester.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max wait cycles per strobe before abort; 0 disables the watchdog
TW, 8, watchdog counter width; must satisfy TIMEOUT < 2**TW

Ports:
wb_clk_i  in  1  single clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
m0_cyc_i / m1_cyc_i  in  1  master bus-cycle request
m0_stb_i / m1_stb_i  in  1  master strobe
m0_we_i / m1_we_i  in  1  master write enable
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  DW/8  master byte selects
m0_ack_o / m1_ack_o  out  1  transfer ack to master
m0_err_o / m1_err_o  out  1  watchdog abort to master
m0_dat_o / m1_dat_o  out  DW  read data to master
s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
s_adr_o  out  AW  to slave
s_dat_o  out  DW  to slave
s_sel_o  out  DW/8  to slave
s_ack_i  in  1  slave ack
s_dat_i  in  DW  slave read data
grant_o  out  2  one-hot current owner (bit0=m0, bit1=m1); 00 when idle
timeout_o  out  1  one-cycle pulse on every watchdog abort

Behaviour:
- Reset (wb_rst_n_i low, async): state=IDLE, wdog=0, last=1 (m0 wins the first tie); all outputs 0.
- FSM states:
  - IDLE: no owner. Request = mN_cyc_i & mN_stb_i. One requester -> BUSN next edge. Both -> the master != last. None -> stay.
  - BUS0 / BUS1: owner's cyc/stb/we/adr/dat/sel drive s_* combinationally. Owner's ack_o = s_ack_i and dat_o = s_dat_i. Non-owner ack/err/dat_o = 0.
  - ABORT0 / ABORT1: exactly one cycle.
- BUSN -> IDLE on the first edge where mN_cyc_i=0; set last=N. s_cyc_o falls in that same cycle because it is combinational.
- Back-to-back requests always pass through one IDLE cycle, giving 1 cycle of grant latency from IDLE. Within a grant, multiple strobes are allowed with no extra latency; this allows locked RMW sequences.
- Watchdog (BUSN only):
  - wdog increments on each cycle with s_stb_o=1 & s_ack_i=0.
  - Clears on s_ack_i, on stb low, and on leaving BUSN.
  - Cycle with wdog==TIMEOUT-1, stb=1, ack=0 -> next state ABORTN.
- ABORTN:
  - s_cyc_o = s_stb_o = 0.
  - mN_err_o = 1, timeout_o = 1, mN_ack_o = 0.
  - Next state IDLE; last=N.
- ack and err are never asserted together. An ack arriving in the would-be-timeout cycle wins and clears wdog.
- A non-owner request is held off (its ack/err stay 0) until the owner releases. Round-robin gives a worst-case wait of one full owner cycle plus 1.
- A master dropping cyc in the same cycle the slave acks: the ack is still routed to it, then the FSM goes to IDLE.
- s_ack_i received in IDLE/ABORT is ignored.
- Reset asserted mid-transfer: immediate return to reset values; s_cyc_o drops asynchronously.

Decomposition:
- Package sudoku_wb_pkg holds:
  - State enum (IDLE, BUS0, BUS1, ABORT0, ABORT1).
  - Address-window constants SUDOKU_BASE=32'h30000000, UART_BASE=32'h30800000, WIN_MASK=32'hFFF00000, shared with the top-level decode.
- One sub-module: wb_watchdog (TW-bit counter; inputs en, clr; output expire at TIMEOUT-1; TIMEOUT=0 -> expire tied 0).

Test Plan:
- Single m0 read of 0x30000004 with the slave acking 2 cycles after stb -> grant_o=01 one cycle after request; m0_ack_o one cycle with m0_dat_o=s_dat_i=0x12345678; m1_ack_o stays 0.
- m0 and m1 request in the same cycle right after reset -> m0 granted first. After m0 drops cyc: one IDLE cycle, then grant_o=10. Repeat the tie -> m0 granted again (alternation).
- m1 holds cyc for a 3-strobe burst while m0 requests -> m0 sees no ack until m1 drops cyc; m0 granted exactly 2 cycles after that.
- Slave never acks, TIMEOUT=4 -> m0_err_o and timeout_o pulse for one cycle on the 5th cycle after the stb cycle; s_cyc_o=0 during that pulse; FSM returns to IDLE; m1 is served next.
- Slave acks in the same cycle wdog reaches TIMEOUT-1 -> ack delivered, no err, no timeout_o pulse.
- wb_rst_n_i pulled low mid-write (s_cyc_o=1) -> s_cyc_o, grant_o and all acks go 0 without a clock edge. After release, m0 wins the first tie.
